// File: rtl/colour_blob_tracker.sv
// Per-frame colour blob statistics: per-colour pixel counts and coordinate sums,
// then a shared serial restoring divider producing red/green centroids at frame end.
module colour_blob_tracker #(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    parameter  int MIN_PIXELS = 64,
    localparam int X_W   = $clog2(IMG_WIDTH),
    localparam int Y_W   = $clog2(IMG_HEIGHT),
    localparam int CNT_W = $clog2(IMG_WIDTH*IMG_HEIGHT+1),
    localparam int XY_W  = (X_W > Y_W) ? X_W : Y_W,
    localparam int SUM_W = CNT_W + XY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             is_red,
    input  logic             is_green,
    input  logic             is_black,
    output logic             result_valid,
    output logic             busy,
    output logic             frame_dropped,
    output logic             red_found,
    output logic [X_W-1:0]   red_cx,
    output logic [Y_W-1:0]   red_cy,
    output logic [CNT_W-1:0] red_count,
    output logic             green_found,
    output logic [X_W-1:0]   green_cx,
    output logic [Y_W-1:0]   green_cy,
    output logic [CNT_W-1:0] green_count,
    output logic [CNT_W-1:0] black_count
);
    localparam int BC_W = $clog2(SUM_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && c != '1) ? c + 1'b1 : c;
    endfunction

    function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] s,
                                                 input logic [XY_W-1:0] v, input logic en);
        logic [SUM_W:0] t;
        t = {1'b0, s} + {{(SUM_W+1-XY_W){1'b0}}, v};
        if (!en) return s;
        return t[SUM_W] ? '1 : t[SUM_W-1:0];
    endfunction

    logic [X_W-1:0]   x_cur, px;
    logic [Y_W-1:0]   y_cur, py;
    logic             in_frame, pix_ok, eop_pix, hit_r, hit_g, hit_b;
    logic [CNT_W-1:0] acc_rc, acc_gc, acc_bc, nxt_rc, nxt_gc, nxt_bc;
    logic [SUM_W-1:0] acc_rx, acc_ry, acc_gx, acc_gy, nxt_rx, nxt_ry, nxt_gx, nxt_gy;

    // SOP pixel starts from a zero base so stale accumulator contents never leak in.
    always_comb begin
        hit_r   = is_red;
        hit_g   = is_green & ~is_red;
        hit_b   = is_black & ~is_red & ~is_green;
        pix_ok  = in_valid & (in_sop | in_frame);
        eop_pix = pix_ok & in_eop;
        if (in_sop) begin
            px = '0;
            py = '0;
        end else if (x_cur == X_W'(IMG_WIDTH-1)) begin
            px = '0;
            py = (y_cur == Y_W'(IMG_HEIGHT-1)) ? y_cur : y_cur + 1'b1;
        end else begin
            px = x_cur + 1'b1;
            py = y_cur;
        end
        nxt_rc = cnt_inc(in_sop ? '0 : acc_rc, hit_r);
        nxt_gc = cnt_inc(in_sop ? '0 : acc_gc, hit_g);
        nxt_bc = cnt_inc(in_sop ? '0 : acc_bc, hit_b);
        nxt_rx = sum_add(in_sop ? '0 : acc_rx, XY_W'(px), hit_r);
        nxt_ry = sum_add(in_sop ? '0 : acc_ry, XY_W'(py), hit_r);
        nxt_gx = sum_add(in_sop ? '0 : acc_gx, XY_W'(px), hit_g);
        nxt_gy = sum_add(in_sop ? '0 : acc_gy, XY_W'(py), hit_g);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cur    <= '0;
            y_cur    <= '0;
            in_frame <= 1'b0;
            acc_rc   <= '0;
            acc_gc   <= '0;
            acc_bc   <= '0;
            acc_rx   <= '0;
            acc_ry   <= '0;
            acc_gx   <= '0;
            acc_gy   <= '0;
        end else if (pix_ok) begin
            x_cur    <= px;
            y_cur    <= py;
            in_frame <= ~in_eop;
            acc_rc   <= in_eop ? '0 : nxt_rc;
            acc_gc   <= in_eop ? '0 : nxt_gc;
            acc_bc   <= in_eop ? '0 : nxt_bc;
            acc_rx   <= in_eop ? '0 : nxt_rx;
            acc_ry   <= in_eop ? '0 : nxt_ry;
            acc_gx   <= in_eop ? '0 : nxt_gx;
            acc_gy   <= in_eop ? '0 : nxt_gy;
        end
    end

    state_t           state;
    logic [1:0]       sel;
    logic [BC_W-1:0]  bit_cnt;
    logic [SUM_W-1:0] dvd, q_nx, dvd_next_src;
    logic [CNT_W-1:0] rem, rem_sub, divisor;
    logic [CNT_W:0]   rem_sh;
    logic             q_bit, r_ok, g_ok;
    logic [X_W-1:0]   q_rx, q_gx;
    logic [Y_W-1:0]   q_ry;
    logic [SUM_W-1:0] snap_rx, snap_ry, snap_gx, snap_gy;
    logic [CNT_W-1:0] snap_rc, snap_gc, snap_bc;

    // One restoring step: quotient bits shift into the dividend register as it empties.
    always_comb begin
        divisor = sel[1] ? snap_gc : snap_rc;
        rem_sh  = {rem, dvd[SUM_W-1]};
        q_bit   = rem_sh >= {1'b0, divisor};
        rem_sub = rem_sh[CNT_W-1:0] - divisor;
        q_nx    = {dvd[SUM_W-2:0], q_bit};
        r_ok    = snap_rc >= CNT_W'(MIN_PIXELS);
        g_ok    = snap_gc >= CNT_W'(MIN_PIXELS);
        case (sel)
            2'd0:    dvd_next_src = snap_ry;
            2'd1:    dvd_next_src = snap_gx;
            default: dvd_next_src = snap_gy;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sel           <= '0;
            bit_cnt       <= '0;
            dvd           <= '0;
            rem           <= '0;
            q_rx          <= '0;
            q_ry          <= '0;
            q_gx          <= '0;
            snap_rx       <= '0;
            snap_ry       <= '0;
            snap_gx       <= '0;
            snap_gy       <= '0;
            snap_rc       <= '0;
            snap_gc       <= '0;
            snap_bc       <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            frame_dropped <= 1'b0;
            red_found     <= 1'b0;
            red_cx        <= '0;
            red_cy        <= '0;
            red_count     <= '0;
            green_found   <= 1'b0;
            green_cx      <= '0;
            green_cy      <= '0;
            green_count   <= '0;
            black_count   <= '0;
        end else begin
            result_valid  <= 1'b0;
            frame_dropped <= eop_pix && (state == DIV);
            case (state)
                DIV: begin
                    rem     <= q_bit ? rem_sub : rem_sh[CNT_W-1:0];
                    dvd     <= q_nx;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == BC_W'(SUM_W-1)) begin
                        bit_cnt <= '0;
                        rem     <= '0;
                        if (sel == 2'd3) begin
                            state        <= DONE;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                            red_found    <= r_ok;
                            red_cx       <= r_ok ? q_rx : '0;
                            red_cy       <= r_ok ? q_ry : '0;
                            red_count    <= snap_rc;
                            green_found  <= g_ok;
                            green_cx     <= g_ok ? q_gx : '0;
                            green_cy     <= g_ok ? q_nx[Y_W-1:0] : '0;
                            green_count  <= snap_gc;
                            black_count  <= snap_bc;
                        end else begin
                            case (sel)
                                2'd0:    q_rx <= q_nx[X_W-1:0];
                                2'd1:    q_ry <= q_nx[Y_W-1:0];
                                default: q_gx <= q_nx[X_W-1:0];
                            endcase
                            sel <= sel + 1'b1;
                            dvd <= dvd_next_src;
                        end
                    end
                end
                default: begin
                    if (eop_pix) begin
                        snap_rc <= nxt_rc;
                        snap_gc <= nxt_gc;
                        snap_bc <= nxt_bc;
                        snap_rx <= nxt_rx;
                        snap_ry <= nxt_ry;
                        snap_gx <= nxt_gx;
                        snap_gy <= nxt_gy;
                        dvd     <= nxt_rx;
                        rem     <= '0;
                        sel     <= '0;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= DIV;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
